hub75_row_fetch: RTL

Upstream feeder for the ICN2038S/HUB75 panel scan driver. On a row request from the driver, it reads one scan row of packed pixels from a synchronous framebuffer RAM. It assembles the six per-channel column vectors (r0,g0,b0 upper half; r1,g1,b1 lower half). It then commits them to stable output registers that the driver shifts out MSB-first. Output registers are double-buffered, so the driver can shift the previous row while the next one is being fetched.

---
 rtl/hub75_pkg.sv | 26 ++
 rtl/hub75_row_fetch.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared constants and FSM encoding for the HUB75 row fetcher and scan driver
package hub75_pkg;

    // Panel geometry shared with the scan driver
    localparam int COLS  = 64;
    localparam int ROWS  = 32;
    localparam int ROW_W = 5;
    localparam int COL_W = 6;

    // Bit positions of each colour channel inside a framebuffer pixel word
    localparam int PIX_R0 = 5;
    localparam int PIX_G0 = 4;
    localparam int PIX_B0 = 3;
    localparam int PIX_R1 = 2;
    localparam int PIX_G1 = 1;
    localparam int PIX_B1 = 0;
    localparam int N_CH   = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/hub75_row_fetch.sv
// rtl/hub75_row_fetch.sv - fetches one scan row from framebuffer RAM into double-buffered channel vectors
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   row_req, row_sel    single-cycle fetch request and the row to fetch (ignored while busy)
//   busy                fetch in progress
//   row_done            one-cycle pulse, committed vectors updated this cycle
//   row_valid           set from the first commit onward
//   row_out             row index of the committed vectors
//   mem_rd_en/mem_addr  framebuffer read strobe and {row, col} address
//   mem_rdata           pixel word {r0,g0,b0,r1,g1,b1}, valid the cycle after mem_rd_en
//   data_r0..data_b1    committed channel vectors, column 0 at the MSB
module hub75_row_fetch
    import hub75_pkg::*;
#(
    parameter int COLS  = hub75_pkg::COLS,
    parameter int ROW_W = hub75_pkg::ROW_W,
    parameter int COL_W = hub75_pkg::COL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   row_req,
    input  logic [ROW_W-1:0]       row_sel,
    output logic                   busy,
    output logic                   row_done,
    output logic                   row_valid,
    output logic [ROW_W-1:0]       row_out,
    output logic                   mem_rd_en,
    output logic [ROW_W+COL_W-1:0] mem_addr,
    input  logic [5:0]             mem_rdata,
    output logic [COLS-1:0]        data_r0,
    output logic [COLS-1:0]        data_g0,
    output logic [COLS-1:0]        data_b0,
    output logic [COLS-1:0]        data_r1,
    output logic [COLS-1:0]        data_g1,
    output logic [COLS-1:0]        data_b1
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    fetch_state_e     state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] row_out_q, row_out_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] col_d1_q, col_d1_d;
    logic             rd_en_q, rd_en_d;
    logic             v_d1_q, v_d1_d;
    logic             row_done_q, row_done_d;
    logic             row_valid_q, row_valid_d;
    logic [COL_W-1:0] cap_idx;

    // Shadow is filled during the fetch; data is what the driver shifts out
    logic [COLS-1:0]  shadow_q [N_CH];
    logic [COLS-1:0]  shadow_d [N_CH];
    logic [COLS-1:0]  data_q   [N_CH];
    logic [COLS-1:0]  data_d   [N_CH];

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        row_out_d   = row_out_q;
        col_d       = col_q;
        rd_en_d     = rd_en_q;
        row_done_d  = 1'b0;
        row_valid_d = row_valid_q;
        // Read data returns one cycle after the strobe, so the column travels with it
        v_d1_d      = rd_en_q;
        col_d1_d    = col_q;
        cap_idx     = COL_LAST - col_d1_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            shadow_d[ch] = shadow_q[ch];
            data_d[ch]   = data_q[ch];
        end

        if (v_d1_q) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                shadow_d[ch][cap_idx] = mem_rdata[ch];
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (row_req) begin
                    row_d   = row_sel;
                    col_d   = '0;
                    rd_en_d = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    rd_en_d = 1'b0;
                    state_d = ST_DRAIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Last word lands in the shadow at the end of this cycle
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    data_d[ch] = shadow_q[ch];
                end
                row_out_d   = row_q;
                row_done_d  = 1'b1;
                row_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            row_out_q   <= '0;
            col_q       <= '0;
            col_d1_q    <= '0;
            rd_en_q     <= 1'b0;
            v_d1_q      <= 1'b0;
            row_done_q  <= 1'b0;
            row_valid_q <= 1'b0;
            for (int ch = 0; ch < N_CH; ch++) begin
                data_q[ch] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            row_out_q   <= row_out_d;
            col_q       <= col_d;
            col_d1_q    <= col_d1_d;
            rd_en_q     <= rd_en_d;
            v_d1_q      <= v_d1_d;
            row_done_q  <= row_done_d;
            row_valid_q <= row_valid_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                data_q[ch] <= data_d[ch];
            end
        end
    end

    // A partially filled shadow is never committed, so it needs no reset
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < N_CH; ch++) begin
            shadow_q[ch] <= shadow_d[ch];
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign row_done  = row_done_q;
    assign row_valid = row_valid_q;
    assign row_out   = row_out_q;
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = {row_q, col_q};
    assign data_r0   = data_q[PIX_R0];
    assign data_g0   = data_q[PIX_G0];
    assign data_b0   = data_q[PIX_B0];
    assign data_r1   = data_q[PIX_R1];
    assign data_g1   = data_q[PIX_G1];
    assign data_b1   = data_q[PIX_B1];

endmodule
